dvi_timing_ctrl: RTL and testbench

Video timing controller that sequences the DVI transmit datapath. It generates hsync/vsync/de and a pixel request stream (x, y) for an upstream pixel source, then aligns the returned RGB with the registered timing. Its outputs feed the TMDS encoders. Default timing is 800x600@60 (40 MHz pixel clock). Start and stop are frame-aligned, so the sink never sees a truncated frame.

---
 rtl/dvi_timing_pkg.sv | 32 +++
 rtl/dvi_timing_axis.sv | 51 +++++
 rtl/dvi_timing_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_dvi_timing_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_timing_pkg.sv
// dvi_timing_pkg: shared types and constants for the DVI timing controller.
// Holds the FSM state type, SVGA 800x600@60 defaults and colour-bar table.
package dvi_timing_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF,
    24'hFFFF00,
    24'h00FFFF,
    24'h00FF00,
    24'hFF00FF,
    24'hFF0000,
    24'h0000FF,
    24'h000000
  };

endpackage

// File: rtl/dvi_timing_axis.sv
// dvi_timing_axis: one timing axis counter (active, FP, SYNC, BP order).
// Ports: clk_i, rst_ni, advance_i, clear_i -> count_o, active_o, sync_o, wrap_o.
module dvi_timing_axis #(
  parameter int ACTIVE = 800,
  parameter int FP     = 40,
  parameter int SYNC   = 128,
  parameter int BP     = 88,
  parameter int W      = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         advance_i,
  input  logic         clear_i,
  output logic [W-1:0] count_o,
  output logic         active_o,
  output logic         sync_o,
  output logic         wrap_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC);
  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (advance_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign active_o = count_q < ACT_END;
  assign sync_o   = (count_q >= SYNC_BEG) && (count_q < SYNC_END);
  assign wrap_o   = count_q == LAST;

endmodule

// File: rtl/dvi_timing_ctrl.sv
// dvi_timing_ctrl: DVI video timing, pixel request stream and 2-stage RGB align.
// Ports: in_clk, in_reset_n, in_enable, in_pattern, in_rgb[23:0] ->
//   out_busy, out_req_de/x/y, out_hsync, out_vsync, out_de, out_rgb,
//   out_frame_start. Macro DVI_TIMING_CTRL_PATTERN_EN adds colour bars.
module dvi_timing_ctrl
  import dvi_timing_pkg::*;
#(
  parameter int H_ACTIVE = SVGA_H_ACTIVE,
  parameter int H_FP     = SVGA_H_FP,
  parameter int H_SYNC   = SVGA_H_SYNC,
  parameter int H_BP     = SVGA_H_BP,
  parameter int V_ACTIVE = SVGA_V_ACTIVE,
  parameter int V_FP     = SVGA_V_FP,
  parameter int V_SYNC   = SVGA_V_SYNC,
  parameter int V_BP     = SVGA_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int X_WIDTH  = 12,
  parameter int Y_WIDTH  = 11
) (
  input  logic               in_clk,
  input  logic               in_reset_n,
  input  logic               in_enable,
  input  logic               in_pattern,
  output logic               out_busy,
  output logic               out_req_de,
  output logic [X_WIDTH-1:0] out_req_x,
  output logic [Y_WIDTH-1:0] out_req_y,
  input  logic [23:0]        in_rgb,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic               out_de,
  output logic [23:0]        out_rgb,
  output logic               out_frame_start
);

  state_e state_q, state_d;

  logic [X_WIDTH-1:0] h_cnt;
  logic [Y_WIDTH-1:0] v_cnt;
  logic h_act, h_sync, h_wrap;
  logic v_act, v_sync, v_wrap;
  logic run, frame_end;

  assign run       = state_q != IDLE;
  assign frame_end = h_wrap & v_wrap;

  // Counters sit at (0,0) while idle so the first RUN cycle is pixel (0,0).
  dvi_timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (X_WIDTH)
  ) u_h_axis (
    .clk_i     (in_clk),
    .rst_ni    (in_reset_n),
    .advance_i (run),
    .clear_i   (!run),
    .count_o   (h_cnt),
    .active_o  (h_act),
    .sync_o    (h_sync),
    .wrap_o    (h_wrap)
  );

  dvi_timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (Y_WIDTH)
  ) u_v_axis (
    .clk_i     (in_clk),
    .rst_ni    (in_reset_n),
    .advance_i (run & h_wrap),
    .clear_i   (!run),
    .count_o   (v_cnt),
    .active_o  (v_act),
    .sync_o    (v_sync),
    .wrap_o    (v_wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_enable) state_d = RUN;
      end
      RUN: begin
        if (!in_enable) state_d = DRAIN;
      end
      DRAIN: begin
        // Re-enable wins so the stream continues seamlessly.
        if (in_enable) begin
          state_d = RUN;
        end else if (frame_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  logic de0, hs0, vs0, fs0;

  assign de0 = run & h_act & v_act;
  assign hs0 = run & h_sync;
  assign vs0 = run & v_sync;
  assign fs0 = de0 & (h_cnt == '0) & (v_cnt == '0);

  assign out_req_de = de0;
  assign out_req_x  = de0 ? h_cnt : '0;
  assign out_req_y  = de0 ? v_cnt : '0;

  logic de_p1, hs_p1, vs_p1, fs_p1;
  logic run_p1, run_p2;

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      de_p1  <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      fs_p1  <= 1'b0;
      run_p1 <= 1'b0;
      run_p2 <= 1'b0;
    end else begin
      de_p1  <= de0;
      hs_p1  <= hs0;
      vs_p1  <= vs0;
      fs_p1  <= fs0;
      run_p1 <= run;
      run_p2 <= run_p1;
    end
  end

  // Busy stays up until the last pixel has left the output stage.
  assign out_busy = run | run_p1 | run_p2;

  logic [23:0] rgb_d;

`ifdef DVI_TIMING_CTRL_PATTERN_EN
  localparam logic [X_WIDTH+2:0] BAR_DIV = H_ACTIVE[X_WIDTH+2:0];

  logic [X_WIDTH+2:0] x8;
  logic [2:0]         bar0, bar_p1;

  // Bar index is (x*8)/H_ACTIVE; only meaningful inside the active line.
  assign x8   = {h_cnt, 3'b000};
  assign bar0 = de0 ? 3'(x8 / BAR_DIV) : 3'd0;

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      bar_p1 <= 3'd0;
    end else begin
      bar_p1 <= bar0;
    end
  end

  always_comb begin
    rgb_d = '0;
    if (de_p1) begin
      rgb_d = in_pattern ? BAR_RGB[bar_p1] : in_rgb;
    end
  end
`else
  logic unused_pattern;
  assign unused_pattern = in_pattern;

  always_comb begin
    rgb_d = '0;
    if (de_p1) rgb_d = in_rgb;
  end
`endif

  logic        hsync_q, vsync_q, de_q, fs_q;
  logic [23:0] rgb_q;

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      hsync_q <= !HS_POL;
      vsync_q <= !VS_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= hs_p1 ? HS_POL : !HS_POL;
      vsync_q <= vs_p1 ? VS_POL : !VS_POL;
      de_q    <= de_p1;
      fs_q    <= fs_p1;
      rgb_q   <= rgb_d;
    end
  end

  assign out_hsync       = hsync_q;
  assign out_vsync       = vsync_q;
  assign out_de          = de_q;
  assign out_frame_start = fs_q;
  assign out_rgb         = rgb_q;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// tb_dvi_timing_ctrl: randomized bench for dvi_timing_ctrl with small timing.
// Reference model tracks a linear frame position and a 2-deep output history.
module tb_dvi_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam bit HSP = 1'b1, VSP = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        pat = 1'b0;
  logic [23:0] rgb_i = '0;

  logic        busy, req_de, hsync, vsync, de, fs;
  logic [11:0] req_x;
  logic [10:0] req_y;
  logic [23:0] rgb_o;

  dvi_timing_ctrl #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL (HSP), .VS_POL (VSP), .X_WIDTH (12), .Y_WIDTH (11)
  ) dut (
    .in_clk          (clk),
    .in_reset_n      (rst_n),
    .in_enable       (en),
    .in_pattern      (pat),
    .out_busy        (busy),
    .out_req_de      (req_de),
    .out_req_x       (req_x),
    .out_req_y       (req_y),
    .in_rgb          (rgb_i),
    .out_hsync       (hsync),
    .out_vsync       (vsync),
    .out_de          (de),
    .out_rgb         (rgb_o),
    .out_frame_start (fs)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit de, hs, vs, fs, run;
    int x, y;
  } ref_t;

  ref_t        hist [3];
  bit          m_run, m_stop;
  int          m_pos;
  int          n_cmp, n_bad, cyc_n;
  logic [23:0] rgb_pend;
  int          fs_at [$];
  logic [23:0] bar_tab [8];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // What the timing at frame position pos must look like.
  function automatic ref_t at_pos(bit run, int pos);
    ref_t r;
    int h = pos % HT;
    int v = pos / HT;
    r.run = run;
    r.de  = run && h < HA && v < VA;
    r.hs  = run && h >= HA + HF && h < HA + HF + HS;
    r.vs  = run && v >= VA + VF && v < VA + VF + VS;
    r.fs  = r.de && pos == 0;
    r.x   = r.de ? h : 0;
    r.y   = r.de ? v : 0;
    return r;
  endfunction

  function automatic logic [23:0] exp_rgb(ref_t o);
    if (!o.de) return 24'h0;
`ifdef DVI_TIMING_CTRL_PATTERN_EN
    if (pat) return bar_tab[(o.x * 8) / HA];
`endif
    return {8'(o.x), 8'(o.y), 8'hA5};
  endfunction

  task automatic model_clear();
    m_run  = 0;
    m_stop = 0;
    m_pos  = 0;
    for (int i = 0; i < 3; i++) hist[i] = at_pos(0, 0);
  endtask

  // A stop request takes effect only after a full frame has finished while
  // it was pending; raising enable again cancels it.
  task automatic model_step();
    if (!rst_n) begin
      model_clear();
      return;
    end
    if (!m_run) begin
      if (en) begin
        m_run  = 1;
        m_stop = 0;
        m_pos  = 0;
      end
    end else begin
      if (m_stop && !en && m_pos == FRAME - 1) m_run = 0;
      m_stop = !en;
      m_pos  = (m_pos + 1) % FRAME;
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = at_pos(m_run, m_pos);
  endtask

  task automatic compare_all();
    ref_t c = hist[0];
    ref_t o = hist[2];
    check("req_de", 32'(req_de), 32'(c.de));
    check("req_x", 32'(req_x), 32'(c.x));
    check("req_y", 32'(req_y), 32'(c.y));
    check("de", 32'(de), 32'(o.de));
    check("hsync", 32'(hsync), 32'(o.hs ? HSP : !HSP));
    check("vsync", 32'(vsync), 32'(o.vs ? VSP : !VSP));
    check("frame_start", 32'(fs), 32'(o.fs));
    check("busy", 32'(busy), 32'(hist[0].run | hist[1].run | hist[2].run));
    check("rgb", 32'(rgb_o), 32'(exp_rgb(o)));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1 rgb_i = rgb_pend;
    @(negedge clk);
    cyc_n++;
    compare_all();
    if (fs) fs_at.push_back(cyc_n);
    // Upstream source answers each request one cycle later.
    rgb_pend = req_de ? {req_x[7:0], req_y[7:0], 8'hA5} : 24'($urandom);
  endtask

  task automatic wait_pos(int pos);
    int k = 0;
    do begin
      step();
      k++;
    end while (!(m_run && m_pos == pos) && k < 4 * FRAME);
    if (!(m_run && m_pos == pos)) check("wait_pos_timeout", 0, 1);
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (busy && k < 4 * FRAME) begin
      step();
      k++;
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    int k;
    int p;
    bar_tab = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    n_cmp = 0;
    n_bad = 0;
    cyc_n = 0;
    rgb_pend = '0;
    model_clear();

    // Reset held, then idle with enable low.
    repeat (3) step();
    rst_n = 1'b1;
    repeat (50) step();

    // Two running frames.
    en = 1'b1;
    repeat (2 * FRAME + 5) step();

    // Stop requested at line 2: frame completes, then flush.
    p = 2 * HT + 3;
    wait_pos(p);
    en = 1'b0;
    wait_idle(k);
    check("busy_fall_delay", 32'(k), 32'(FRAME - 1 - p + 3));
    repeat (20) step();

    // Stop then re-enable during drain: no gap between frames.
    fs_at.delete();
    en = 1'b1;
    wait_pos(HT + 2);
    en = 1'b0;
    wait_pos(5 * HT + 1);
    en = 1'b1;
    repeat (3 * FRAME) step();
    check("fs_count", 32'(fs_at.size() >= 4), 1);
    for (int i = 1; i < fs_at.size(); i++)
      check("frame_period", 32'(fs_at[i] - fs_at[i-1]), 32'(FRAME));
    en = 1'b0;
    wait_idle(k);

    // Random enable activity.
    repeat (1500) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
`ifndef DVI_TIMING_CTRL_PATTERN_EN
      pat = 1'($urandom_range(0, 1));
`endif
      step();
    end

    // Asynchronous reset in the middle of a frame.
    en = 1'b1;
    wait_pos(HT + 5);
    #2 rst_n = 1'b0;
    model_clear();
    #1 compare_all();
    en = 1'b0;
    repeat (5) step();
    rst_n = 1'b1;
    repeat (10) step();

`ifdef DVI_TIMING_CTRL_PATTERN_EN
    pat = 1'b1;
    en = 1'b1;
    repeat (FRAME + 10) step();
    en = 1'b0;
    wait_idle(k);
    pat = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
